pm_frame_gen: RTL
=================

Name: pm_frame_gen

Overview:
- Paced traffic source: turns each rate tick from the upstream pacing counter (one pulse per frame slot) into one SIZE-byte AXI-Stream frame.
- Absorbs ticks that arrive while a frame is in flight, up to MAX_PENDING.
- Counts ticks lost beyond that limit.
- Sits between the pacing counter and the MAC/loopback path under test.

Parameters:
- SIZE, 64, frame length in bytes; must be >= SEQ_WIDTH/8.
- DATA_WIDTH, 64, AXI-Stream data width in bits; a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- MAX_PENDING, 4, maximum queued ticks; must be >= 1.
- SEQ_WIDTH, 32, sequence/frame counter width; a multiple of 8 and <= DATA_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  accept ticks when high
- tick_in  in  1  single-cycle pacing pulse, sampled on rising clk
- m_axis_tdata  out  DATA_WIDTH  frame data
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- m_axis_tlast  out  1  last beat of frame
- frame_count  out  SEQ_WIDTH  frames completed; wraps
- drop_count  out  32  ticks dropped; saturates at 2^32-1
- busy  out  1  high in SEND state or when pending != 0

Behaviour:
- Reset (async assert): state=IDLE, pending=0, beat=0.
  - All outputs 0: tvalid, tlast, tdata, tkeep, frame_count, drop_count, busy.
  - A frame in flight is aborted immediately; no tlast is emitted.
- Geometry:
  - BEATS = ceil(SIZE/KEEP_WIDTH).
  - Beats 0..BEATS-2 have tkeep all ones.
  - Last beat tkeep = low (SIZE mod KEEP_WIDTH) bits set, or all ones if the remainder is 0.
  - BEATS=1 is legal: tlast is set on beat 0.
- Frame content (byte k = frame byte index, little-endian across the bus, byte k at tdata[8*(k mod KEEP_WIDTH)+:8]):
  - Bytes 0..SEQ_WIDTH/8-1 = the frame's sequence number. This is the frame_count value when beat 0 is first presented.
  - Every other byte = k mod 256.
  - Bytes with tkeep=0 are 0.
- Tick accounting (each clock):
  - A tick counts only when tick_in && enable.
  - A counted tick with pending < MAX_PENDING increments pending.
  - A counted tick with pending == MAX_PENDING increments drop_count.
  - A frame start decrements pending.
  - Counted tick and frame start in the same cycle: pending unchanged, no drop.
  - enable low: pending is cleared to 0; the current frame completes normally.
- State machine:
  - IDLE: if pending > 0, go to SEND, decrement pending, beat=0, tvalid=1 from the next cycle. A tick sampled at edge T therefore gives tvalid=1 after edge T+1.
  - SEND: beat advances on tvalid && tready.
  - On the handshake of beat BEATS-1 (tlast=1), frame_count increments.
    - If pending > 0: start the next frame back-to-back (decrement pending, beat=0, tvalid stays 1, no idle cycle).
    - Else: go to IDLE and drop tvalid.
- AXI rules:
  - While tvalid && !tready, tdata/tkeep/tlast are held stable.
  - tvalid never drops before its handshake, except on reset.
- Wrap: frame_count wraps modulo 2^SEQ_WIDTH; drop_count saturates.
- Output timing: all outputs are registered; no combinational path from tready to tvalid.

Test Plan:
- Defaults, tready=1, one tick at cycle 10 -> tvalid rises after edge 11. Then 8 contiguous beats, tkeep=0xFF, tlast on beat 7. Beat 0 tdata=0x07060504_00000000, beat 1=0x0F0E0D0C_0B0A0908. frame_count=1, busy=0 afterwards.
- SIZE=60, one tick -> 8 beats. Last beat tkeep=0x0F, tdata=0x00000000_3B3A3938, tlast=1.
- Three ticks on consecutive cycles, tready=1 -> 24 contiguous beats, no gaps; seq fields 0, 1, 2; frame_count=3, drop_count=0.
- MAX_PENDING=4, tready=0, 10 ticks on consecutive cycles -> tick 1 starts a frame. Tick 2 coincides with that start, so pending stays 1. Ticks 2..5 bring pending to 4; ticks 6..10 are dropped, drop_count=5. Raising tready then yields 5 frames back-to-back.
- tready toggling 1/0 each cycle during a frame -> tdata/tkeep/tlast held while stalled. All 8 beats delivered in order, and the frame ends in exactly 16 cycles.
- rst asserted while beat 3 is presented -> tvalid=0 immediately with no tlast, and all counters read 0. A tick after release produces a frame with seq=0. Separately, enable=0 with pending=3 -> pending cleared; the in-flight frame completes and no further frames follow.

Source files
------------

// File: rtl/pm_frame_gen.sv
// pm_frame_gen -- paced traffic source.
// Each counted pacing tick becomes one SIZE-byte AXI-Stream frame.
// Ticks that arrive while a frame is in flight are queued, up to MAX_PENDING.
// Ticks beyond that limit are counted in a saturating drop counter.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   enable            accept ticks when high; low clears the pending queue
//   tick_in           single-cycle pacing pulse
//   m_axis_*          AXI-Stream master (tdata/tkeep/tvalid/tready/tlast)
//   frame_count       frames completed (wraps)
//   drop_count        ticks dropped (saturates)
//   busy              frame in flight or ticks pending
module pm_frame_gen #(
   parameter int SIZE        = 64,
   parameter int DATA_WIDTH  = 64,
   parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
   parameter int MAX_PENDING = 4,
   parameter int SEQ_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  tick_in,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [SEQ_WIDTH-1:0]  frame_count,
   output logic [31:0]           drop_count,
   output logic                  busy
);

   localparam int BEATS     = (SIZE + KEEP_WIDTH - 1) / KEEP_WIDTH;
   localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PEND_W    = $clog2(MAX_PENDING + 1);
   localparam int SEQ_BYTES = SEQ_WIDTH / 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

   logic [0:0]           state_reg, state_next;
   logic [BEAT_W-1:0]    beat_reg, beat_next;
   logic [SEQ_WIDTH-1:0] seq_reg, seq_next;
   logic [PEND_W-1:0]    pending_reg, pending_next;
   logic [SEQ_WIDTH-1:0] frame_count_next;
   logic [31:0]          drop_count_next;
   logic                 valid_next;
   logic                 frame_start;
   logic                 tick_ok;
   logic                 start_ok;

   // Beat contents are computed for the beat that will be presented next
   // and registered, so every AXI output comes straight from a flop.
   logic [DATA_WIDTH-1:0] data_pre;
   logic [KEEP_WIDTH-1:0] keep_pre;

   generate
      for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
         logic [31:0] lane_idx;
         assign lane_idx     = 32'(beat_next) * 32'(KEEP_WIDTH) + 32'(gi);
         assign keep_pre[gi] = (lane_idx < 32'(SIZE));
         if (gi < SEQ_BYTES) begin : g_seq
            // Sequence bytes only ever land in beat 0.
            assign data_pre[8*gi +: 8] = !keep_pre[gi]      ? 8'h00 :
                                         (beat_next == '0)  ? seq_next[8*gi +: 8] :
                                                              lane_idx[7:0];
         end else begin : g_pat
            assign data_pre[8*gi +: 8] = keep_pre[gi] ? lane_idx[7:0] : 8'h00;
         end
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      beat_next        = beat_reg;
      seq_next         = seq_reg;
      valid_next       = m_axis_tvalid;
      frame_count_next = frame_count;
      drop_count_next  = drop_count;
      pending_next     = pending_reg;
      frame_start      = 1'b0;
      tick_ok          = tick_in && enable;
      // A low enable flushes the queue, so it also blocks new frame starts.
      start_ok         = enable && (pending_reg != '0);

      case (state_reg)
         ST_IDLE: begin
            if (start_ok) begin
               frame_start = 1'b1;
               state_next  = ST_SEND;
               beat_next   = '0;
               seq_next    = frame_count;
               valid_next  = 1'b1;
            end
         end
         default: begin
            if (m_axis_tvalid && m_axis_tready) begin
               if (beat_reg == LAST_BEAT) begin
                  frame_count_next = frame_count + SEQ_WIDTH'(1);
                  beat_next        = '0;
                  if (start_ok) begin
                     // Back-to-back frame: its sequence number is the
                     // count that becomes visible together with beat 0.
                     frame_start = 1'b1;
                     seq_next    = frame_count_next;
                  end else begin
                     state_next = ST_IDLE;
                     valid_next = 1'b0;
                  end
               end else begin
                  beat_next = beat_reg + BEAT_W'(1);
               end
            end
         end
      endcase

      if (!enable) begin
         pending_next = '0;
      end else if (tick_ok && !frame_start) begin
         if (pending_reg == PEND_MAX) begin
            if (drop_count != 32'hFFFF_FFFF)
               drop_count_next = drop_count + 32'd1;
         end else begin
            pending_next = pending_reg + PEND_W'(1);
         end
      end else if (!tick_ok && frame_start) begin
         pending_next = pending_reg - PEND_W'(1);
      end
      // Tick and frame start in the same cycle cancel: pending unchanged.
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         beat_reg      <= '0;
         seq_reg       <= '0;
         pending_reg   <= '0;
         frame_count   <= '0;
         drop_count    <= '0;
         busy          <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
      end else begin
         state_reg     <= state_next;
         beat_reg      <= beat_next;
         seq_reg       <= seq_next;
         pending_reg   <= pending_next;
         frame_count   <= frame_count_next;
         drop_count    <= drop_count_next;
         busy          <= (state_next == ST_SEND) || (pending_next != '0);
         m_axis_tvalid <= valid_next;
         m_axis_tlast  <= valid_next && (beat_next == LAST_BEAT);
         m_axis_tdata  <= valid_next ? data_pre : '0;
         m_axis_tkeep  <= valid_next ? keep_pre : '0;
      end
   end

endmodule
